// File: rtl/cpu_pkg.sv
// Shared core definitions: RISC-V load/store size encodings and the dmem FSM state type.
package cpu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/mem_align.sv
// Little-endian lane steering for RV32 loads/stores: byte enables, replicated store word,
// extended load data and the misaligned/illegal-size flag.
module mem_align
  import cpu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        bad
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = raw[{addr_lo, 3'b000} +: 8];
  assign rhalf = raw[{addr_lo[1], 4'b0000} +: 16];

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = '0;
    wword = '0;
    rdata = '0;
    bad   = 1'b0;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = {{24{rbyte[7]}}, rbyte};
      end
      SZ_BU: begin
        be    = 4'b0001 << addr_lo;
        rdata = {24'd0, rbyte};
        bad   = we;
      end
      SZ_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{rhalf[15]}}, rhalf};
        bad   = addr_lo[0];
      end
      SZ_HU: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata = {16'd0, rhalf};
        bad   = we | addr_lo[0];
      end
      SZ_W: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = raw;
        bad   = (addr_lo != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, programmable wait
// states, one response per accepted request.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_e state, state_nx;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [2:0]  cap_size;
  logic [31:0] cap_wdata;

  logic        accept;
  logic        access;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic [31:0] sel_wdata;
  logic [AW-1:0] word_idx;
  logic        range_err;
  logic        align_bad;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] raw;
  logic [31:0] align_rdata;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          access   = 1'b1;
        end
      end
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, before the capture
  // registers load, so the live request feeds the datapath while in IDLE.
  assign sel_we    = (state == IDLE) ? req_we    : cap_we;
  assign sel_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign sel_size  = (state == IDLE) ? req_size  : cap_size;
  assign sel_wdata = (state == IDLE) ? req_wdata : cap_wdata;

  assign word_idx  = sel_addr[AW+1:2];
  assign range_err = ({2'b00, sel_addr[31:2]} >= DEPTH_WORDS);
  assign err       = align_bad | range_err;
  assign raw       = mem[word_idx];

  mem_align u_align (
    .addr_lo (sel_addr[1:0]),
    .size    (sel_size),
    .we      (sel_we),
    .wdata   (sel_wdata),
    .raw     (raw),
    .be      (be),
    .wword   (wword),
    .rdata   (align_rdata),
    .bad     (align_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_size  <= req_size;
        cap_wdata <= req_wdata;
        cnt       <= (WAIT_CYCLES == 0) ? '0 : 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_rdata <= (err || sel_we) ? '0 : align_rdata;
        rsp_err   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && sel_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 4 and 0 wait states) driven with directed
// and random requests, checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WC [3] = '{2, 4, 0};

  logic        clk;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [2:0]  req_size  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;
  int last_rwait;
  int last_lat;
  logic [31:0] last_rdata;
  logic        last_err;

  logic [7:0] refm [int];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(4)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int u, input logic [31:0] a);
    return u * 4096 + int'(a[11:0]);
  endfunction

  // Reference: byte-granular memory, size -> byte count, plain arithmetic for extension.
  function automatic void model(input int u, input logic we, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    int nb;
    bit sgn;
    logic [31:0] v;
    logic [31:0] t;
    rd = 32'd0;
    er = 1'b0;
    sgn = 0;
    case (size)
      3'd0: begin nb = 1; sgn = 1; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd2: nb = 4;
      3'd4: nb = 1;
      3'd5: nb = 2;
      default: nb = 0;
    endcase
    if (nb == 0 || (we && size >= 3'd4)) begin er = 1'b1; return; end
    if ((addr % nb) != 0 || (addr / 4) >= DEPTH) begin er = 1'b1; return; end
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        t = wdata >> (8 * i);
        refm[key(u, addr + i)] = t[7:0];
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(refm[key(u, addr + i)]) << (8 * i));
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata, input int hold,
                     input string tag);
    int n;
    logic [31:0] exp_rd;
    logic exp_er;
    model(u, we, addr, size, wdata, exp_rd, exp_er);
    @(negedge clk);
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr;
    req_size[u] = size; req_wdata[u] = wdata;
    rsp_ready[u] = (hold == 0);
    n = 0;
    while (!req_ready[u] && n < 20) begin @(negedge clk); n++; end
    last_rwait = n;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    req_we[u] = 1'($urandom); req_addr[u] = $urandom;
    req_size[u] = 3'($urandom); req_wdata[u] = $urandom;
    n = 0;
    while (!rsp_valid[u] && n < 40) begin @(posedge clk); #1; n++; end
    last_lat = n; last_rdata = rsp_rdata[u]; last_err = rsp_err[u];
    chk({tag, "_lat"}, n, WC[u]);
    chk({tag, "_rdata"}, rsp_rdata[u], exp_rd);
    chk({tag, "_err"}, rsp_err[u], exp_er);
    if (hold > 0) begin
      req_valid[u] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, rsp_valid[u], 1);
        chk({tag, "_hold_rdata"}, rsp_rdata[u], exp_rd);
        chk({tag, "_hold_ready"}, req_ready[u], 0);
      end
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_rsp_done"}, rsp_valid[u], 0);
    chk({tag, "_ready_back"}, req_ready[u], 1);
    rsp_ready[u] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    bit seen;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
      req_size[u] = '0; req_wdata[u] = '0; rsp_ready[u] = 1'b0;
    end
    #7;
    for (int u = 0; u < 3; u++) begin
      chk("reset_req_ready", req_ready[u], 1);
      chk("reset_rsp_valid", rsp_valid[u], 0);
      chk("reset_rdata", rsp_rdata[u], 0);
      chk("reset_err", rsp_err[u], 0);
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;

    // Two wait states: word round trip, lanes, errors, backpressure.
    txn(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0, "sw10");
    txn(0, 0, 32'h10, 3'b010, 32'h0, 0, "lw10");
    chk("lw10_const", last_rdata, 32'hDEADBEEF);
    txn(0, 1, 32'h20, 3'b010, 32'h11223344, 0, "sw20");
    txn(0, 1, 32'h21, 3'b000, 32'hFFFFFF80, 0, "sb21");
    txn(0, 0, 32'h21, 3'b000, 32'h0, 0, "lb21");
    chk("lb21_const", last_rdata, 32'hFFFFFF80);
    txn(0, 0, 32'h21, 3'b100, 32'h0, 0, "lbu21");
    chk("lbu21_const", last_rdata, 32'h00000080);
    txn(0, 1, 32'h22, 3'b001, 32'h00008001, 0, "sh22");
    txn(0, 0, 32'h22, 3'b001, 32'h0, 0, "lh22");
    chk("lh22_const", last_rdata, 32'hFFFF8001);
    txn(0, 0, 32'h20, 3'b010, 32'h0, 0, "lw20");
    chk("lw20_const", last_rdata, 32'h80018044);
    txn(0, 0, 32'h13, 3'b010, 32'h0, 0, "lw13_mis");
    chk("lw13_err", last_err, 1);
    chk("lw13_rdata0", last_rdata, 0);
    txn(0, 1, 32'h11, 3'b001, 32'h0000AAAA, 0, "sh11_mis");
    chk("sh11_err", last_err, 1);
    txn(0, 0, 32'h10, 3'b010, 32'h0, 0, "lw10_after");
    chk("lw10_after_const", last_rdata, 32'hDEADBEEF);
    txn(0, 0, DEPTH * 4, 3'b010, 32'h0, 0, "lw_oor");
    chk("lw_oor_err", last_err, 1);
    txn(0, 0, 32'h10, 3'b011, 32'h0, 0, "size011");
    chk("size011_err", last_err, 1);
    txn(0, 1, 32'h10, 3'b100, 32'h0, 0, "sbu_illegal");
    chk("sbu_illegal_err", last_err, 1);
    txn(0, 0, 32'h10, 3'b010, 32'h0, 5, "bp");
    txn(0, 0, 32'h20, 3'b010, 32'h0, 0, "after_bp");
    chk("after_bp_accept_wait", last_rwait, 0);

    // Four wait states: reset pulse in WAIT drops the pending store.
    txn(1, 1, 32'h40, 3'b010, 32'hA5A5A5A5, 0, "u1_sw40");
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40;
    req_size[1] = 3'b010; req_wdata[1] = 32'h12345678; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    chk("rstwait_rsp_valid", rsp_valid[1], 0);
    chk("rstwait_req_ready", req_ready[1], 1);
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) seen = 1;
    end
    chk("rstwait_no_rsp", 32'(seen), 0);
    rsp_ready[1] = 1'b0;
    txn(1, 0, 32'h40, 3'b010, 32'h0, 0, "u1_lw40");
    chk("u1_lw40_const", last_rdata, 32'hA5A5A5A5);

    // Zero wait states.
    txn(2, 1, 32'h30, 3'b010, 32'hCAFEF00D, 0, "u2_sw30");
    txn(2, 0, 32'h30, 3'b010, 32'h0, 0, "u2_lw30");
    chk("u2_lw30_const", last_rdata, 32'hCAFEF00D);

    // Random traffic on every instance.
    for (int u = 0; u < 3; u++) begin
      for (int w = 0; w < 16; w++) txn(u, 1, 32'(w * 4), 3'b010, $urandom, 0, "fill");
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
        else a = 32'($urandom_range(0, 63));
        txn(u, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
            int'($urandom_range(0, 2)), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
